// File: rtl/axis2axi_in_pkg.sv
// Shared definitions for the AXI-Stream to AXI4 write block: FSM encoding,
// fixed AW attribute values and the 4 KB burst boundary helper.
package axis2axi_in_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEGIN = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam logic [2:0]  AXI_SIZE_4B    = 3'd2;
  localparam logic [1:0]  AXI_BURST_INCR = 2'd1;
  localparam logic [3:0]  AXI_CACHE_VAL  = 4'd2;
  localparam logic [2:0]  AXI_PROT_VAL   = 3'd2;
  localparam logic [12:0] BOUNDARY_4K    = 13'h1000;

  // Number of 32-bit words left before the next 4 KB page starts (1..1024).
  function automatic logic [12:0] words_to_4k(input logic [11:0] addr_lo);
    logic [12:0] gap;
    gap = BOUNDARY_4K - {1'b0, addr_lo};
    return {2'b00, gap[12:2]};
  endfunction

endpackage

// File: rtl/axis2axi_in_buffer.sv
// Synchronous FIFO of 2^DEPTH_W words with occupancy output; overflow and
// underflow requests are ignored.
module axis2axi_in_buffer #(
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 1
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_n_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic [DEPTH_W:0]  level_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int DEPTH = 1 << DEPTH_W;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W:0]   level_q, level_d;
  logic               do_push, do_pop;

  assign full_o  = (level_q == (DEPTH_W + 1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Pointer and occupancy update; simultaneous push and pop keeps level.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (cke_i) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (cke_i && do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/axis2axi_in.sv
// AXI-Stream to AXI4 write master. Buffers stream words and writes them as
// INCR bursts of up to 2^BURST_W beats, never crossing a 4 KB page.
// Optional macro AXIS2AXI_IN_ERR_EN adds sticky write-response error ports.
//
//   state    | meaning
//   ST_IDLE  | waiting for a config handshake
//   ST_BEGIN | waiting until the next burst is fully buffered
//   ST_ADDR  | AW channel valid
//   ST_DATA  | streaming W beats from the buffer
//   ST_RESP  | waiting for the B response
module axis2axi_in
  import axis2axi_in_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 1,
  parameter int BURST_W    = 0
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    arst_n_i,
  input  logic [AXI_ADDR_W-1:0]   config_in_addr_i,
  input  logic [AXI_ADDR_W-1:0]   config_in_length_i,
  input  logic                    config_in_valid_i,
  output logic                    config_in_ready_o,
  input  logic [AXI_DATA_W-1:0]   axis_in_data_i,
  input  logic                    axis_in_valid_i,
  output logic                    axis_in_ready_o,
  output logic [AXI_ID_W-1:0]     axi_awid_o,
  output logic [AXI_ADDR_W-1:0]   axi_awaddr_o,
  output logic [AXI_LEN_W-1:0]    axi_awlen_o,
  output logic [2:0]              axi_awsize_o,
  output logic [1:0]              axi_awburst_o,
  output logic                    axi_awlock_o,
  output logic [3:0]              axi_awcache_o,
  output logic [2:0]              axi_awprot_o,
  output logic [3:0]              axi_awqos_o,
  output logic                    axi_awvalid_o,
  input  logic                    axi_awready_i,
  output logic [AXI_DATA_W-1:0]   axi_wdata_o,
  output logic [AXI_DATA_W/8-1:0] axi_wstrb_o,
  output logic                    axi_wlast_o,
  output logic                    axi_wvalid_o,
  input  logic                    axi_wready_i,
  input  logic [AXI_ID_W-1:0]     axi_bid_i,
  input  logic [1:0]              axi_bresp_i,
  input  logic                    axi_bvalid_i,
  output logic                    axi_bready_o
`ifdef AXIS2AXI_IN_ERR_EN
  ,
  output logic                    error_o,
  output logic [1:0]              error_resp_o
`endif
);

  localparam int LEVEL_W   = BURST_W + 2;
  localparam int MAX_BEATS = 1 << BURST_W;

  state_e                state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d, length_q, length_d;
  logic [AXI_ADDR_W-1:0] remaining_q, remaining_d, accepted_q, accepted_d;
  logic [AXI_LEN_W-1:0]  awlen_q, awlen_d, beat_q, beat_d;
  logic [AXI_ADDR_W-1:0] burst, burst_bnd;
  logic [LEVEL_W-1:0]    level;
  logic                  buf_full, buf_empty, push, pop;
  logic [AXI_DATA_W-1:0] buf_data;
  logic                  unused_b;

  assign unused_b = ^{axi_bid_i, axi_bresp_i};

  assign axi_awid_o    = '0;
  assign axi_awsize_o  = AXI_SIZE_4B;
  assign axi_awburst_o = AXI_BURST_INCR;
  assign axi_awlock_o  = 1'b0;
  assign axi_awcache_o = AXI_CACHE_VAL;
  assign axi_awprot_o  = AXI_PROT_VAL;
  assign axi_awqos_o   = '0;
  assign axi_wstrb_o   = '1;
  assign axi_awaddr_o  = addr_q;
  assign axi_awlen_o   = awlen_q;
  assign axi_wdata_o   = buf_data;

  assign push = axis_in_valid_i && axis_in_ready_o;
  assign pop  = axi_wvalid_o && axi_wready_i;

  axis2axi_in_buffer #(
    .DATA_W (AXI_DATA_W),
    .DEPTH_W(BURST_W + 1)
  ) u_buffer (
    .clk_i   (clk_i),
    .cke_i   (cke_i),
    .arst_n_i(arst_n_i),
    .push_i  (push),
    .data_i  (axis_in_data_i),
    .pop_i   (pop),
    .data_o  (buf_data),
    .level_o (level),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  // Page clamp only exists when the address space can hold more than 4 KB.
  generate
    if (AXI_ADDR_W >= 13) begin : g_clamp
      assign burst_bnd = AXI_ADDR_W'(words_to_4k(addr_q[11:0]));
    end else begin : g_noclamp
      assign burst_bnd = AXI_ADDR_W'(MAX_BEATS);
    end
  endgenerate

  // Next burst length: smallest of max burst, words left and words to page end.
  always_comb begin
    burst = AXI_ADDR_W'(MAX_BEATS);
    if (remaining_q < burst) burst = remaining_q;
    if (burst_bnd < burst)   burst = burst_bnd;
  end

`ifdef AXIS2AXI_IN_ERR_EN
  logic       err_q, err_d;
  logic [1:0] err_resp_q, err_resp_d;
  assign error_o      = err_q;
  assign error_resp_o = err_resp_q;

  // Sticky error capture keeps the first failing response until next config.
  always_comb begin
    err_d      = err_q;
    err_resp_d = err_resp_q;
    if (state_q == ST_IDLE && config_in_valid_i) begin
      err_d      = 1'b0;
      err_resp_d = 2'b00;
    end else if (axi_bvalid_i && axi_bready_o && axi_bresp_i != 2'b00 && !err_q) begin
      err_d      = 1'b1;
      err_resp_d = axi_bresp_i;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      err_q      <= 1'b0;
      err_resp_q <= 2'b00;
    end else if (cke_i) begin
      err_q      <= err_d;
      err_resp_q <= err_resp_d;
    end
  end
`endif

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      length_q    <= '0;
      remaining_q <= '0;
      accepted_q  <= '0;
      awlen_q     <= '0;
      beat_q      <= '0;
    end else if (cke_i) begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      length_q    <= length_d;
      remaining_q <= remaining_d;
      accepted_q  <= accepted_d;
      awlen_q     <= awlen_d;
      beat_q      <= beat_d;
    end
  end

  // Next-state and counter updates.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    length_d    = length_q;
    remaining_d = remaining_q;
    accepted_d  = push ? accepted_q + AXI_ADDR_W'(1) : accepted_q;
    awlen_d     = awlen_q;
    beat_d      = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (config_in_valid_i) begin
          addr_d      = config_in_addr_i;
          length_d    = config_in_length_i;
          remaining_d = config_in_length_i;
          accepted_d  = '0;
          beat_d      = '0;
          state_d     = (config_in_length_i == '0) ? ST_IDLE : ST_BEGIN;
        end
      end
      ST_BEGIN: begin
        if (AXI_ADDR_W'(level) >= burst) begin
          awlen_d     = AXI_LEN_W'(burst - AXI_ADDR_W'(1));
          remaining_d = remaining_q - burst;
          state_d     = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (axi_awready_i) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (pop) begin
          if (beat_q == awlen_q) begin
            beat_d  = '0;
            state_d = ST_RESP;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (axi_bvalid_i) begin
          addr_d  = addr_q + AXI_ADDR_W'({awlen_q, 2'b00}) + AXI_ADDR_W'(4);
          state_d = (remaining_q == '0) ? ST_IDLE : ST_BEGIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    config_in_ready_o = (state_q == ST_IDLE);
    axis_in_ready_o   = (state_q != ST_IDLE) && !buf_full && (accepted_q < length_q);
    axi_awvalid_o     = (state_q == ST_ADDR);
    axi_wvalid_o      = (state_q == ST_DATA) && !buf_empty;
    axi_wlast_o       = (state_q == ST_DATA) && (beat_q == awlen_q);
    axi_bready_o      = (state_q == ST_RESP);
  end

endmodule
